// File: rtl/hud_text_rom_if.sv
// hud_text_rom_if: HUD text fetch bus between the background renderer and the text ROM
//   x_count : glyph column index driven by the renderer (master)
//   y_count : glyph row index driven by the renderer (master)
//   data    : registered pixel bit returned by the text ROM (slave)
interface hud_text_rom_if;
   logic [7:0] x_count;
   logic [3:0] y_count;
   logic       data;
   modport master (output x_count, y_count, input data);
   modport slave  (input x_count, y_count, output data);
endinterface

// File: rtl/hud_text_rom.sv
// hud_text_rom: HUD status-band text ROM with game-time and score counters
//   clock_25    : pixel clock
//   resetn      : asynchronous active-low reset
//   game_run    : time prescaler advances while high
//   score_inc   : one-cycle pulse, score +1 (saturates at 9999)
//   game_clear  : one-cycle pulse, zero prescaler, time and score
//   frame_start : one-cycle pulse, latch live counters into display shadows
//   hif         : fetch bus (x_count/y_count in, data out one cycle later)
//   time_bcd    : live seconds, 3 BCD digits (saturates at 999)
//   score_bcd   : live score, 4 BCD digits
module hud_text_rom #(
   parameter int TICK_DIV   = 25000000,
   parameter int GLYPH_ROW0 = 2
) (
   input  logic          clock_25,
   input  logic          resetn,
   input  logic          game_run,
   input  logic          score_inc,
   input  logic          game_clear,
   input  logic          frame_start,
   hud_text_rom_if.slave hif,
   output logic [11:0]   time_bcd,
   output logic [15:0]   score_bcd
);
   localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
   localparam logic [4:0] R0 = 5'(GLYPH_ROW0);
   localparam logic [4:0] C_T = 5'd10, C_I = 5'd11, C_M = 5'd12, C_E = 5'd13, C_S = 5'd14,
                          C_C = 5'd15, C_O = 5'd16, C_R = 5'd17, C_CO = 5'd18, C_BL = 5'd19;
   logic [PW-1:0] r_pre;
   logic [11:0]   r_time, r_time_sh;
   logic [15:0]   r_score, r_score_sh;
   logic          r_data;
   logic          w_tick, w_row_ok, w_pix;
   logic [7:0]    w_off;
   logic [4:0]    w_code, w_yy;
   logic [3:0]    w_row;
   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        c;
      r = v;
      c = 1'b1;
      for (int k = 0; k < 4; k++)
         if (c) begin
            if (r[k*4 +: 4] == 4'd9) r[k*4 +: 4] = 4'd0;
            else begin
               r[k*4 +: 4] = r[k*4 +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      return r;
   endfunction
   // Each glyph is 10 rows of 6 bits, row 0 first, column 0 as the MSB of its row.
   function automatic logic font(input logic [4:0] code, input logic [3:0] row, input logic [2:0] col);
      logic [59:0] g;
      logic [59:0] s;
      case (code)
         5'd0: g = 60'b111111_100001_100001_100001_100001_100001_100001_100001_100001_111111;
         5'd1: g = 60'b001000_001000_001000_001000_001000_001000_001000_001000_001000_001000;
         5'd2: g = 60'b111111_000001_000001_000001_111111_100000_100000_100000_100000_111111;
         5'd3: g = 60'b111111_000001_000001_000001_111111_000001_000001_000001_000001_111111;
         5'd4: g = 60'b100001_100001_100001_100001_111111_000001_000001_000001_000001_000001;
         5'd5: g = 60'b111111_100000_100000_100000_111111_000001_000001_000001_000001_111111;
         5'd6: g = 60'b111111_100000_100000_100000_111111_100001_100001_100001_100001_111111;
         5'd7: g = 60'b111111_000001_000010_000100_001000_001000_001000_001000_001000_001000;
         5'd8: g = 60'b111111_100001_100001_100001_111111_100001_100001_100001_100001_111111;
         5'd9: g = 60'b111111_100001_100001_100001_111111_000001_000001_000001_000001_111111;
         C_T:  g = 60'b111111_001100_001100_001100_001100_001100_001100_001100_001100_001100;
         C_I:  g = 60'b111111_001100_001100_001100_001100_001100_001100_001100_001100_111111;
         C_M:  g = 60'b100001_110011_101101_101101_100001_100001_100001_100001_100001_100001;
         C_E:  g = 60'b111111_100000_100000_100000_111110_100000_100000_100000_100000_111111;
         C_S:  g = 60'b011111_100000_100000_100000_011110_000001_000001_000001_000001_111110;
         C_C:  g = 60'b011111_100000_100000_100000_100000_100000_100000_100000_100000_011111;
         C_O:  g = 60'b011110_100001_100001_100001_100001_100001_100001_100001_100001_011110;
         C_R:  g = 60'b111110_100001_100001_100001_111110_101000_100100_100010_100001_100001;
         C_CO: g = 60'b000000_000000_001100_001100_000000_000000_001100_001100_000000_000000;
         default: g = '0;
      endcase
      s = g << (7'(row) * 7'd6 + 7'(col));
      return row < 4'd10 && col < 3'd6 && s[59];
   endfunction
   assign w_tick = game_run && r_pre == PMAX;
   assign w_yy = {1'b0, hif.y_count};
   assign w_row_ok = w_yy >= R0 && w_yy < R0 + 5'd10;
   assign w_row = 4'(w_yy - R0);
   // Map x_count to a cell offset and glyph code; digits come only from the frame shadows.
   always_comb begin
      w_off  = 8'd0;
      w_code = C_BL;
      if (hif.x_count < 8'd40) begin
         w_off  = hif.x_count;
         w_code = w_off[5:3] == 3'd0 ? C_T : w_off[5:3] == 3'd1 ? C_I : w_off[5:3] == 3'd2 ? C_M :
                  w_off[5:3] == 3'd3 ? C_E : C_CO;
      end else if (hif.x_count < 8'd62) begin
         w_off  = hif.x_count - 8'd40;
         w_code = {1'b0, (w_off[4:3] == 2'd0 ? r_time_sh[11:8] :
                          w_off[4:3] == 2'd1 ? r_time_sh[7:4] : r_time_sh[3:0])};
      end else if (hif.x_count < 8'd110) begin
         w_off  = hif.x_count - 8'd62;
         w_code = w_off[5:3] == 3'd0 ? C_S : w_off[5:3] == 3'd1 ? C_C : w_off[5:3] == 3'd2 ? C_O :
                  w_off[5:3] == 3'd3 ? C_R : w_off[5:3] == 3'd4 ? C_E : C_CO;
      end else if (hif.x_count < 8'd142) begin
         w_off  = hif.x_count - 8'd110;
         w_code = {1'b0, (w_off[4:3] == 2'd0 ? r_score_sh[15:12] : w_off[4:3] == 2'd1 ? r_score_sh[11:8] :
                          w_off[4:3] == 2'd2 ? r_score_sh[7:4] : r_score_sh[3:0])};
      end
   end
   assign w_pix = w_row_ok && font(w_code, w_row, w_off[2:0]);
   always_ff @(posedge clock_25 or negedge resetn)
      if (!resetn) begin
         r_pre      <= '0;
         r_time     <= '0;
         r_score    <= '0;
         r_time_sh  <= '0;
         r_score_sh <= '0;
         r_data     <= 1'b0;
      end else begin
         r_data <= w_pix;
         if (frame_start) begin
            r_time_sh  <= r_time;
            r_score_sh <= r_score;
         end
         if (game_clear) begin
            r_pre   <= '0;
            r_time  <= '0;
            r_score <= '0;
         end else begin
            if (game_run) r_pre <= w_tick ? '0 : r_pre + 1'b1;
            if (w_tick && r_time != 12'h999) r_time <= 12'(bcd_inc({4'h0, r_time}));
            if (score_inc && r_score != 16'h9999) r_score <= bcd_inc(r_score);
         end
      end
   assign hif.data  = r_data;
   assign time_bcd  = r_time;
   assign score_bcd = r_score;
endmodule

// File: tb/tb_hud_text_rom.sv
// tb_hud_text_rom: directed self-checking bench for hud_text_rom (TICK_DIV=4, GLYPH_ROW0=2)
module tb_hud_text_rom;
   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        game_run = 1'b0, score_inc = 1'b0, game_clear = 1'b0, frame_start = 1'b0;
   logic [11:0] time_bcd;
   logic [15:0] score_bcd;
   int          checks = 0, passed = 0;
   hud_text_rom_if hif ();
   hud_text_rom #(.TICK_DIV(4), .GLYPH_ROW0(2)) dut (
      .clock_25(clk), .resetn(resetn), .game_run(game_run), .score_inc(score_inc),
      .game_clear(game_clear), .frame_start(frame_start), .hif(hif),
      .time_bcd(time_bcd), .score_bcd(score_bcd));
   always #5 clk = ~clk;
   task automatic step;
      @(posedge clk);
      #1;
   endtask
   task automatic probe(input logic [7:0] x, input logic [3:0] y, output logic d);
      hif.x_count = x;
      hif.y_count = y;
      step();
      d = hif.data;
   endtask
   task automatic clear_pulse;
      game_clear = 1'b1;
      step();
      game_clear = 1'b0;
   endtask
   task automatic test_reset;
      hif.x_count = 8'd0;
      hif.y_count = 4'd2;
      repeat (2) step();
      checks++; if (hif.data !== 1'b0) $display("FAIL reset_data got %b want 0", hif.data); else passed++;
      checks++; if (time_bcd !== 12'h0) $display("FAIL reset_time got %h want 000", time_bcd); else passed++;
      checks++; if (score_bcd !== 16'h0) $display("FAIL reset_score got %h want 0000", score_bcd); else passed++;
      resetn = 1'b1;
   endtask
   task automatic test_time;
      game_run = 1'b1;
      for (int i = 1; i <= 4000; i++) begin
         step();
         if (i == 4) begin
            checks++; if (time_bcd !== 12'h001) $display("FAIL time_first got %h want 001", time_bcd); else passed++;
         end
         if (i == 40) begin
            checks++; if (time_bcd !== 12'h010) $display("FAIL time_carry got %h want 010", time_bcd); else passed++;
         end
         if (i == 3995) begin
            checks++; if (time_bcd !== 12'h998) $display("FAIL time_998 got %h want 998", time_bcd); else passed++;
         end
         if (i == 3996) begin
            checks++; if (time_bcd !== 12'h999) $display("FAIL time_999 got %h want 999", time_bcd); else passed++;
         end
      end
      checks++; if (time_bcd !== 12'h999) $display("FAIL time_sat got %h want 999", time_bcd); else passed++;
      game_run = 1'b0;
   endtask
   task automatic test_time_hold;
      clear_pulse();
      checks++; if (time_bcd !== 12'h0) $display("FAIL time_clear got %h want 000", time_bcd); else passed++;
      game_run = 1'b1;
      repeat (2) step();
      game_run = 1'b0;
      repeat (5) step();
      game_run = 1'b1;
      step();
      checks++; if (time_bcd !== 12'h0) $display("FAIL hold_early got %h want 000", time_bcd); else passed++;
      step();
      checks++; if (time_bcd !== 12'h001) $display("FAIL hold_tick got %h want 001", time_bcd); else passed++;
      game_run = 1'b0;
   endtask
   task automatic test_score;
      score_inc = 1'b1;
      for (int i = 1; i <= 10001; i++) begin
         step();
         if (i == 10) begin
            checks++; if (score_bcd !== 16'h0010) $display("FAIL score_10 got %h want 0010", score_bcd); else passed++;
         end
         if (i == 100) begin
            checks++; if (score_bcd !== 16'h0100) $display("FAIL score_100 got %h want 0100", score_bcd); else passed++;
         end
         if (i == 9999) begin
            checks++; if (score_bcd !== 16'h9999) $display("FAIL score_9999 got %h want 9999", score_bcd); else passed++;
         end
      end
      checks++; if (score_bcd !== 16'h9999) $display("FAIL score_sat got %h want 9999", score_bcd); else passed++;
      score_inc = 1'b0;
   endtask
   task automatic test_priority;
      logic [7:0] xs [5] = '{8'd126, 8'd134, 8'd110, 8'd112, 8'd118};
      logic [3:0] ys [5] = '{4'd2, 4'd7, 4'd3, 4'd3, 4'd2};
      logic       ex [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      logic       d;
      clear_pulse();
      score_inc = 1'b1;
      repeat (42) step();
      score_inc = 1'b0;
      checks++; if (score_bcd !== 16'h0042) $display("FAIL score_42 got %h want 0042", score_bcd); else passed++;
      score_inc = 1'b1;
      game_clear = 1'b1;
      frame_start = 1'b1;
      step();
      score_inc = 1'b0;
      game_clear = 1'b0;
      frame_start = 1'b0;
      checks++; if (score_bcd !== 16'h0) $display("FAIL clear_prio got %h want 0000", score_bcd); else passed++;
      for (int i = 0; i < 5; i++) begin
         probe(xs[i], ys[i], d);
         checks++; if (d !== ex[i]) $display("FAIL shadow_0042_%0d x=%0d y=%0d got %b want %b", i, xs[i], ys[i], d, ex[i]); else passed++;
      end
   endtask
   task automatic test_shadow;
      logic d;
      score_inc = 1'b1;
      repeat (43) step();
      score_inc = 1'b0;
      checks++; if (score_bcd !== 16'h0043) $display("FAIL score_43 got %h want 0043", score_bcd); else passed++;
      probe(8'd134, 4'd7, d);
      checks++; if (d !== 1'b1) $display("FAIL stale_units_c0 got %b want 1", d); else passed++;
      probe(8'd139, 4'd7, d);
      checks++; if (d !== 1'b0) $display("FAIL stale_units_c5 got %b want 0", d); else passed++;
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      probe(8'd134, 4'd7, d);
      checks++; if (d !== 1'b0) $display("FAIL fresh_units_c0 got %b want 0", d); else passed++;
      probe(8'd139, 4'd7, d);
      checks++; if (d !== 1'b1) $display("FAIL fresh_units_c5 got %b want 1", d); else passed++;
   endtask
   task automatic test_glyph;
      logic [9:0] i_col0 = 10'b1000000001;
      logic [7:0] xs [11] = '{8'd8, 8'd8, 8'd8, 8'd150, 8'd0, 8'd43, 8'd43, 8'd45, 8'd46, 8'd61, 8'd63};
      logic [3:0] ys [11] = '{4'd0, 4'd1, 4'd12, 4'd2, 4'd2, 4'd2, 4'd6, 4'd6, 4'd2, 4'd2, 4'd2};
      logic       ex [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      logic       d;
      hif.x_count = 8'd8;
      hif.y_count = 4'd2;
      for (int r = 0; r < 10; r++) begin
         step();
         d = hif.data;
         if (r < 9) hif.y_count = 4'(3 + r);
         checks++; if (d !== i_col0[r]) $display("FAIL glyph_I_row%0d got %b want %b", r, d, i_col0[r]); else passed++;
      end
      for (int i = 0; i < 11; i++) begin
         probe(xs[i], ys[i], d);
         checks++; if (d !== ex[i]) $display("FAIL pixel_%0d x=%0d y=%0d got %b want %b", i, xs[i], ys[i], d, ex[i]); else passed++;
      end
   endtask
   task automatic test_reset_mid;
      clear_pulse();
      hif.x_count = 8'd0;
      hif.y_count = 4'd2;
      game_run = 1'b1;
      repeat (492) step();
      checks++; if (time_bcd !== 12'h123) $display("FAIL mid_time got %h want 123", time_bcd); else passed++;
      checks++; if (hif.data !== 1'b1) $display("FAIL mid_data got %b want 1", hif.data); else passed++;
      #1 resetn = 1'b0;
      #1;
      checks++; if (time_bcd !== 12'h0) $display("FAIL async_time got %h want 000", time_bcd); else passed++;
      checks++; if (score_bcd !== 16'h0) $display("FAIL async_score got %h want 0000", score_bcd); else passed++;
      checks++; if (hif.data !== 1'b0) $display("FAIL async_data got %b want 0", hif.data); else passed++;
      step();
      resetn = 1'b1;
      repeat (3) step();
      checks++; if (time_bcd !== 12'h0) $display("FAIL restart_early got %h want 000", time_bcd); else passed++;
      step();
      checks++; if (time_bcd !== 12'h001) $display("FAIL restart_tick got %h want 001", time_bcd); else passed++;
      game_run = 1'b0;
   endtask
   initial begin
      test_reset();
      test_time();
      test_time_hold();
      test_score();
      test_priority();
      test_shadow();
      test_glyph();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/hud_text_rom.md
Name: hud_text_rom

Overview:
- Responder side of the HUD text fetch interface.
- The background renderer drives x_count/y_count while its raster is inside the status band (Y 460..475). This block returns one pixel bit on data.
- Renders the static labels "TIME:" and "SCORE:" plus live decimal digits for elapsed time and score.
- Owns the 1 Hz game-time counter and the score counter, and frame-latches the displayed digits so they never tear mid-frame.

Parameters:
- TICK_DIV, 25000000: clock_25 cycles per game-time second.
- GLYPH_ROW0, 2: first y_count row of glyph bitmaps.

Ports:
- clock_25  in  1  25 MHz pixel clock.
- resetn  in  1  asynchronous, active-low reset.
- x_count  in  8  glyph column index from background.
- y_count  in  4  glyph row index from background (0..15).
- game_run  in  1  level; time counter advances only while high.
- score_inc  in  1  single-cycle pulse; score +1.
- game_clear  in  1  single-cycle pulse; zero both counters and the prescaler.
- frame_start  in  1  single-cycle pulse at frame start; loads the display shadows.
- data  out  1  pixel bit for (x_count, y_count), registered.
- time_bcd  out  12  live time, 3 BCD digits (seconds).
- score_bcd  out  16  live score, 4 BCD digits.

Behaviour:
- Reset (resetn=0, async): data=0, prescaler=0, time_bcd=0, score_bcd=0, both shadows=0. Release is synchronous to clock_25.
- Prescaler counts 0..TICK_DIV-1 while game_run=1, then wraps and emits an internal tick. It holds its value while game_run=0.
- On tick, time_bcd increments as BCD with digit carry. It saturates at 999; no wrap.
- On score_inc, score_bcd increments as BCD. It saturates at 9999.
- game_clear has priority over tick and score_inc in the same cycle. It zeroes the prescaler, time_bcd and score_bcd at the next edge.
- On frame_start, time_shadow and score_shadow load the current live registers, i.e. pre-update values if a tick, score_inc or game_clear occurs in the same cycle. Digits shown on data come only from the shadows.
- Glyph cells are 8 columns wide. The font is 6 columns x 10 rows; columns 6,7 are blank spacing. Glyph column = (x_count - cell_base) mod 8.
- Glyph row = y_count - GLYPH_ROW0 when y_count is in GLYPH_ROW0..GLYPH_ROW0+9. Other rows render 0.
- Column map for x_count:
  - 0..39: "TIME:" (cells T,I,M,E,colon at bases 0,8,16,24,32).
  - 40..61: time digits hundreds/tens/units at bases 40,48,56. The units cell is clipped at 61; only its blank columns are lost.
  - 62..109: "SCORE:" (6 cells at base 62+8k, k=0..5).
  - 110..141: score digits thousands..units at bases 110,118,126,134.
  - 142..255: data=0.
- Font ROM is a combinational case on (glyph code, row, column). Codes: 0..9, T, I, M, E, S, C, O, R, colon.
  - "0": 6x10 outline with a filled top and bottom row.
  - "1": column 2 set in all rows.
  - The remaining glyphs are defined in the font table checked in alongside this block.
- Latency: data at edge n+1 reflects x_count/y_count sampled at edge n (1 cycle). No pipeline stall and no handshake; the requester may change address every cycle.
- x_count/y_count outside the defined areas must return 0, never X.

Test Plan:
- TICK_DIV=4, game_run=1 for 4000 cycles → time_bcd reaches 12'h999 at cycle 3996 and holds 12'h999 thereafter.
- 10000 score_inc pulses → score_bcd=16'h9999. A further pulse leaves 16'h9999. After pulse 10, score_bcd=16'h0010 (BCD carry).
- score=16'h0042, then assert score_inc and game_clear in the same cycle → score_bcd=0 next cycle.
- Same-cycle frame_start → score shadow renders "0042".
- Live score changes to 0043 with no frame_start → units cell still renders glyph "2". After the next frame_start it renders "3".
- x_count=8, y_count=GLYPH_ROW0..+9 sweep → data, one cycle later, matches the "I" column-0 bitmap. x_count=150 or y_count=0 → data=0.
- resetn low mid-count (time=12'h123) → time_bcd, score_bcd and data go to 0 immediately, without a clock edge. After release the prescaler restarts from 0, so the first tick comes TICK_DIV cycles later.
